// File: rtl/disp_scan_sched.sv
// disp_scan_sched: multiplexed display scan scheduler.
//
// Walks the enabled digit groups (group n = register pair 2n/2n+1). For each group it
// requests a segment-data load from the digit datapath, optionally blanks every select
// line for a few ticks, then drives that group's select line for SHOW_TICKS ticks.
//
// Optional feature: define DISP_BLANK_EN to insert the all-off BLANK phase between the
// load and the show phase. Without it, a group is shown on the cycle after load_ack.
//
// Parameters:
//   SHOW_TICKS   - cycles a group is driven on sel_out (1..15)
//   BLANK_TICKS  - cycles of all-off between load and show (1..15, DISP_BLANK_EN only)
//   LOAD_TIMEOUT - cycles load_req may wait for load_ack (1..15)
//
// Ports:
//   clk_300Hz   in   scan clock, all state changes on its rising edge
//   sl_rst_wire in   asynchronous active-low reset
//   grp_en      in   [3:0] bit n high = group n takes part in the scan
//   hold_req    in   level, pins the scan on group hold_sel
//   hold_sel    in   [1:0] group to pin while hold_req is high
//   load_ack    in   datapath has latched the group's segment data
//   load_req    out  request to latch group grp_idx
//   grp_idx     out  [1:0] group being loaded or shown
//   sel_out     out  [3:0] one-hot select, group 0 = bit 3, group 3 = bit 0
//   frame_done  out  one-cycle pulse when the scan wraps
//   err_timeout out  sticky load-timeout flag, cleared only by reset

module disp_scan_sched #(
  parameter int unsigned SHOW_TICKS   = 3,
  parameter int unsigned BLANK_TICKS  = 1,
  parameter int unsigned LOAD_TIMEOUT = 4
) (
  input  logic       clk_300Hz,
  input  logic       sl_rst_wire,
  input  logic [3:0] grp_en,
  input  logic       hold_req,
  input  logic [1:0] hold_sel,
  input  logic       load_ack,
  output logic       load_req,
  output logic [1:0] grp_idx,
  output logic [3:0] sel_out,
  output logic       frame_done,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StBlank = 2'd2,
    StShow  = 2'd3
  } state_e;

  // Terminal counts: the phase ends on the edge where the counter holds these values.
  localparam logic [3:0] ShowLast  = 4'(SHOW_TICKS - 1);
  localparam logic [3:0] ToLast    = 4'(LOAD_TIMEOUT - 1);
  localparam logic [3:0] BlankLast = 4'(BLANK_TICKS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] grp_q, grp_d;
  logic       frame_q, frame_d;
  logic       err_q, err_d;

  logic [1:0] first_incl;
  logic [1:0] next_strict;
  logic [1:0] pick;
  logic       hold_ok;

  // First enabled group at offset 0..4 (incl) or 1..4 (strict) from 'from', wrapping.
  // Offset 4 lands back on 'from', so a single enabled group selects itself.
  function automatic logic [1:0] find_en(input logic [3:0] en, input logic [1:0] from,
                                         input logic incl);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = from;
    found = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = from + 2'(k);
      if (!found && (incl || (k != 0)) && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign first_incl  = find_en(grp_en, grp_q, 1'b1);
  assign next_strict = find_en(grp_en, grp_q, 1'b0);
  // A hold on a disabled group is ignored and the normal scan continues.
  assign hold_ok     = hold_req && grp_en[hold_sel];
  assign pick        = hold_ok ? hold_sel : next_strict;

`ifndef DISP_BLANK_EN
  logic unused_blank_last;
  assign unused_blank_last = ^BlankLast;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    frame_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (grp_en != 4'b0000) begin
          state_d = StLoad;
          grp_d   = first_incl;
          cnt_d   = 4'd0;
        end
      end
      StLoad: begin
        // Ack has priority over a timeout expiring on the same edge.
        if (load_ack) begin
          cnt_d = 4'd0;
`ifdef DISP_BLANK_EN
          state_d = StBlank;
`else
          state_d = StShow;
`endif
        end else if (cnt_q == ToLast) begin
          // Give up on the load and show whatever the datapath still holds.
          err_d   = 1'b1;
          state_d = StShow;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`ifdef DISP_BLANK_EN
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      StShow: begin
        if (cnt_q == ShowLast) begin
          // Selection point: grp_en and hold are only looked at here and in IDLE.
          cnt_d = 4'd0;
          if (grp_en == 4'b0000) begin
            state_d = StIdle;
          end else begin
            state_d = StLoad;
            grp_d   = pick;
            frame_d = (pick <= grp_q);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_300Hz or negedge sl_rst_wire) begin
    if (!sl_rst_wire) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      grp_q   <= 2'd0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign load_req    = (state_q == StLoad);
  assign grp_idx     = grp_q;
  assign sel_out     = (state_q == StShow) ? (4'b1000 >> grp_q) : 4'b0000;
  assign frame_done  = frame_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_disp_scan_sched.sv
// Self-checking bench for disp_scan_sched. A per-visit timeline model builds the
// expected output of every cycle from the scan rules; directed phases plus a random
// phase drive the DUT against it.

module tb_disp_scan_sched;

  localparam int ShowT = 3;
  localparam int BlankT = 1;
  localparam int ToT = 4;
`ifdef DISP_BLANK_EN
  localparam int BlankEff = BlankT;
`else
  localparam int BlankEff = 0;
`endif
  localparam int P = 1 + BlankEff + ShowT;

  logic       clk_300Hz = 1'b0;
  logic       sl_rst_wire = 1'b1;
  logic [3:0] grp_en = 4'b0000;
  logic       hold_req = 1'b0;
  logic [1:0] hold_sel = 2'd0;
  logic       load_ack = 1'b0;
  logic       load_req;
  logic [1:0] grp_idx;
  logic [3:0] sel_out;
  logic       frame_done;
  logic       err_timeout;

  disp_scan_sched #(
    .SHOW_TICKS  (ShowT),
    .BLANK_TICKS (BlankT),
    .LOAD_TIMEOUT(ToT)
  ) dut (
    .clk_300Hz  (clk_300Hz),
    .sl_rst_wire(sl_rst_wire),
    .grp_en     (grp_en),
    .hold_req   (hold_req),
    .hold_sel   (hold_sel),
    .load_ack   (load_ack),
    .load_req   (load_req),
    .grp_idx    (grp_idx),
    .sel_out    (sel_out),
    .frame_done (frame_done),
    .err_timeout(err_timeout)
  );

  always #5 clk_300Hz = ~clk_300Hz;

  typedef struct {
    logic [3:0] sel;
    logic       lr;
    logic [1:0] idx;
    logic       fd;
    logic       err;
    logic       ack;    // value the bench drives on load_ack in this cycle
    logic       selpt;  // the edge closing this cycle is a selection point
    logic       fi;     // selection point taken from IDLE (inclusive search)
  } rec_t;

  rec_t       exp_q[$];
  int         n_total = 0;
  int         n_bad = 0;
  logic       m_err;
  logic [1:0] m_cur;
  int         ack_mode;  // 0 immediate, 1 never, 2 random, 3 on the timeout edge
  bit         rand_inputs;
  logic [3:0] tb_en;
  logic       tb_hr;
  logic [1:0] tb_hs;
  logic [3:0] last_sel;
  logic       last_lr, last_fd, last_err;
  logic [1:0] last_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic spur();
    return (ack_mode == 2) ? 1'($urandom_range(1)) : 1'b0;
  endfunction

  function automatic logic [1:0] first_en(input logic [3:0] en, input logic [1:0] from,
                                          input bit incl);
    int idx;
    for (int k = incl ? 0 : 1; k <= 4; k++) begin
      idx = (int'(from) + k) % 4;
      if (en[idx]) return 2'(idx);
    end
    return from;
  endfunction

  task automatic push(input logic [3:0] sel, input logic lr, input logic [1:0] idx,
                      input logic fd, input logic ack, input logic selpt, input logic fi);
    rec_t r;
    r.sel = sel; r.lr = lr; r.idx = idx; r.fd = fd; r.err = m_err;
    r.ack = ack; r.selpt = selpt; r.fi = fi;
    exp_q.push_back(r);
  endtask

  task automatic push_idle();
    push(4'b0000, 1'b0, m_cur, 1'b0, spur(), 1'b1, 1'b1);
  endtask

  // One complete visit: load (ack after d waiting cycles), blank, show.
  task automatic push_visit(input logic [1:0] g, input logic f);
    int d, nl;
    bit tmo;
    case (ack_mode)
      0:       d = 0;
      1:       d = 100;
      3:       d = ToT - 1;
      default: d = int'($urandom_range(5));
    endcase
    tmo = (d >= ToT);
    nl  = tmo ? ToT : d + 1;
    for (int i = 0; i < nl; i++)
      push(4'b0000, 1'b1, g, (i == 0) ? f : 1'b0, (i == d), 1'b0, 1'b0);
    if (tmo) m_err = 1'b1;
    else for (int i = 0; i < BlankEff; i++) push(4'b0000, 1'b0, g, 1'b0, spur(), 1'b0, 1'b0);
    for (int i = 0; i < ShowT; i++)
      push(4'b1000 >> g, 1'b0, g, 1'b0, spur(), (i == ShowT - 1), 1'b0);
    m_cur = g;
  endtask

  task automatic extend();
    logic [1:0] g;
    if (tb_en == 4'b0000) begin
      push_idle();
    end else if (exp_q[0].fi) begin
      push_visit(first_en(tb_en, m_cur, 1'b1), 1'b0);
    end else begin
      g = (tb_hr && tb_en[tb_hs]) ? tb_hs : first_en(tb_en, m_cur, 1'b0);
      push_visit(g, g <= m_cur);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_err = 1'b0;
    m_cur = 2'd0;
    push_idle();
    last_sel = 4'b0; last_lr = 1'b0; last_fd = 1'b0; last_err = 1'b0; last_idx = 2'd0;
  endtask

  task automatic step();
    rec_t r;
    @(negedge clk_300Hz);
    if (rand_inputs) begin
      if ($urandom_range(7) == 0) tb_en = 4'($urandom_range(15));
      if ($urandom_range(5) == 0) tb_hr = 1'($urandom_range(1));
      if ($urandom_range(5) == 0) tb_hs = 2'($urandom_range(3));
    end
    grp_en = tb_en; hold_req = tb_hr; hold_sel = tb_hs;
    if (exp_q.size() == 1 && exp_q[0].selpt) extend();
    r = exp_q.pop_front();
    load_ack = r.ack;
    #1;
    check_eq("sel_out", sel_out, r.sel);
    check_eq("load_req", load_req, r.lr);
    check_eq("grp_idx", grp_idx, r.idx);
    check_eq("frame_done", frame_done, r.fd);
    check_eq("err_timeout", err_timeout, r.err);
    last_sel = sel_out; last_lr = load_req; last_fd = frame_done;
    last_err = err_timeout; last_idx = grp_idx;
  endtask

  task automatic do_reset();
    sl_rst_wire = 1'b0;
    load_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("rst_sel", sel_out, 0);
      check_eq("rst_load_req", load_req, 0);
      check_eq("rst_grp_idx", grp_idx, 0);
      check_eq("rst_frame", frame_done, 0);
      check_eq("rst_err", err_timeout, 0);
      repeat (2) @(posedge clk_300Hz);
    end
    @(posedge clk_300Hz);
    #2;
    sl_rst_wire = 1'b1;
    model_reset();
  endtask

  task automatic window(input int n, output int fd, output logic [3:0] mask, output int s0,
                        output int gap);
    int   last_rise;
    logic prev;
    last_rise = -1; prev = last_lr; fd = 0; mask = 4'b0; s0 = 0; gap = 0;
    for (int i = 0; i < n; i++) begin
      step();
      fd   += int'(last_fd);
      mask |= last_sel;
      if (last_sel == 4'b1000) s0++;
      if (last_lr && !prev) begin
        if (last_rise >= 0) gap = i - last_rise;
        last_rise = i;
      end
      prev = last_lr;
    end
  endtask

  initial begin
    int fd, s0, gap, n;
    logic [3:0] mask;
    tb_en = 4'b0; tb_hr = 1'b0; tb_hs = 2'd0; ack_mode = 0; rand_inputs = 0;
    #2;
    do_reset();
    repeat (3) step();  // nothing enabled: stays idle

    // Full scan, immediate ack.
    tb_en = 4'hF;
    repeat (10) step();
    window(8 * P, fd, mask, s0, gap);
    check_eq("all_frames", fd, 2);
    check_eq("all_mask", mask, 4'hF);
    check_eq("all_g0_cycles", s0, 2 * ShowT);
    check_eq("all_period", gap, P);

    // Groups 0 and 2 only.
    tb_en = 4'b0101;
    repeat (4 * P) step();
    window(8 * P, fd, mask, s0, gap);
    check_eq("g02_frames", fd, 4);
    check_eq("g02_mask", mask, 4'b1010);

    // Load timeout, then ack resumes.
    do_reset();
    tb_en = 4'hF; ack_mode = 1;
    n = 0;
    while (!last_lr && n < 20) begin step(); n++; end
    check_eq("to_seen", last_lr, 1);
    n = 0;
    while (last_lr && n < 20) begin n++; step(); end
    check_eq("to_len", n, ToT);
    check_eq("to_err", last_err, 1);
    check_eq("to_sel", last_sel, 4'b1000);
    n = 0;
    while (last_sel != 4'b0 && n < 20) begin n++; step(); end
    check_eq("to_show_len", n, ShowT);
    ack_mode = 0;
    repeat (30) step();
    check_eq("to_sticky", err_timeout, 1);

    // Ack on the same edge the timeout expires: ack wins.
    do_reset();
    ack_mode = 3;
    repeat (60) step();
    check_eq("race_err", err_timeout, 0);

    // Hold on group 2 mid-scan, then hold on a disabled group.
    do_reset();
    ack_mode = 0;
    repeat (7) step();
    tb_hr = 1'b1; tb_hs = 2'd2;
    repeat (8 * P) step();
    window(4 * P, fd, mask, s0, gap);
    check_eq("hold_frames", fd, 4);
    check_eq("hold_mask", mask, 4'b0010);
    tb_hs = 2'd1; tb_en = 4'b1101;
    repeat (8 * P) step();
    window(6 * P, fd, mask, s0, gap);
    check_eq("hold_off_frames", fd, 2);
    check_eq("hold_off_mask", mask, 4'b1011);
    tb_hr = 1'b0;

    // Reset mid-SHOW, restart at group 0.
    tb_en = 4'hF;
    n = 0;
    while (last_sel == 4'b0 && n < 20) begin step(); n++; end
    check_eq("show_seen", (last_sel != 4'b0), 1);
    do_reset();
    step();
    step();
    check_eq("restart_lr", last_lr, 1);
    check_eq("restart_idx", last_idx, 0);

    // Reset mid-LOAD.
    repeat (2) step();
    n = 0;
    while (!last_lr && n < 20) begin step(); n++; end
    check_eq("load_seen", last_lr, 1);
    do_reset();

    // Random phase.
    ack_mode = 2; rand_inputs = 1;
    repeat (3000) step();
    rand_inputs = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/disp_scan_sched.md
DISP_SCAN_SCHED -- requirements
Module: disp_scan_sched

Interface
- REQ-001 The block SHALL have parameter SHOW_TICKS, default 3: clk_300Hz cycles a group is driven on sel_out (legal 1..15).
- REQ-002 The block SHALL have parameter BLANK_TICKS, default 1: cycles of all-off between load and show (legal 1..15).
- REQ-003 The block SHALL have parameter LOAD_TIMEOUT, default 4: cycles load_req may wait for load_ack (legal 1..15).
- REQ-004 The block SHALL have port clk_300Hz, input, 1 bit: scan clock; all state changes on its rising edge.
- REQ-005 The block SHALL have port sl_rst_wire, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 The block SHALL have port grp_en, input, 4 bits: bit n high = group n (register pair 2n/2n+1) is included in the scan.
- REQ-007 The block SHALL have port hold_req, input, 1 bit: level; pins the scan on group hold_sel.
- REQ-008 The block SHALL have port hold_sel, input, 2 bits: group index to pin while hold_req is high.
- REQ-009 The block SHALL have port load_ack, input, 1 bit: the digit datapath has latched the group's segment data.
- REQ-010 The block SHALL have port load_req, output, 1 bit: request to the datapath to latch group grp_idx.
- REQ-011 The block SHALL have port grp_idx, output, 2 bits: index of the group being loaded or shown.
- REQ-012 The block SHALL have port sel_out, output, 4 bits: one-hot, active-high digit-group select; group 0 = bit 3, group 3 = bit 0.
- REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the scan wraps.
- REQ-014 The block SHALL have port err_timeout, output, 1 bit: sticky load-timeout flag.

Function
- REQ-015 The FSM SHALL have the states IDLE, LOAD, BLANK and SHOW.
- REQ-016 sel_out SHALL be 0 in IDLE, LOAD and BLANK, and onehot(grp_idx) only in SHOW.
- REQ-017 In IDLE with grp_en==0 the FSM SHALL stay in IDLE.
- REQ-018 In IDLE with grp_en!=0, the next edge SHALL enter LOAD with load_req=1 and grp_idx = the lowest enabled index at or after grp_idx, searching upward with wrap 3->0.
- REQ-019 In LOAD, load_req SHALL stay high until load_ack is sampled high; that edge SHALL clear load_req and enter BLANK.
- REQ-020 If LOAD_TIMEOUT cycles elapse in LOAD without load_ack, the FSM SHALL set err_timeout, clear load_req and enter SHOW with stale data.
- REQ-021 If load_ack arrives on the same edge the timeout expires, ack SHALL win and err_timeout SHALL remain unchanged.
- REQ-022 BLANK SHALL last exactly BLANK_TICKS cycles and then enter SHOW.
- REQ-023 SHOW SHALL last exactly SHOW_TICKS cycles.
- REQ-024 On the final SHOW edge, if grp_en==0 the FSM SHALL enter IDLE and clear sel_out.
- REQ-025 On the final SHOW edge, if hold_req=1 and grp_en[hold_sel]=1 the FSM SHALL select next = hold_sel.
- REQ-026 On the final SHOW edge, if REQ-025 does not apply (including hold_req=1 with hold_sel disabled), the FSM SHALL select next = the next enabled index strictly after grp_idx, with wrap.
- REQ-027 After selecting next (REQ-025/REQ-026), the FSM SHALL enter LOAD with load_req=1.
- REQ-028 frame_done SHALL pulse on the final SHOW edge whenever next <= current grp_idx, including a single enabled group and hold.
- REQ-029 grp_en and hold_req/hold_sel SHALL be sampled only at selection points; changes mid-LOAD, BLANK or SHOW SHALL not shorten or abort the current group.
- REQ-030 With immediate ack, the per-group period SHALL be 1 + BLANK_TICKS + SHOW_TICKS cycles (5 at defaults).

Reset
- REQ-031 While sl_rst_wire=0, the block SHALL asynchronously force state IDLE, sel_out=0, grp_idx=0, load_req=0, frame_done=0, err_timeout=0 and all tick counters to 0.
- REQ-032 Reset asserted mid-LOAD SHALL drop load_req immediately, and a pending load_ack SHALL be ignored afterwards.
- REQ-033 err_timeout SHALL be cleared only by reset.

Configuration
- REQ-034 With macro DISP_BLANK_EN defined, the BLANK state SHALL be present as specified.
- REQ-035 Without DISP_BLANK_EN, LOAD SHALL go directly to SHOW on ack, BLANK_TICKS SHALL be ignored, and the per-group period SHALL be 1 + SHOW_TICKS cycles.

Verification
- REQ-036 The bench SHALL cover: grp_en=4'b1111, ack tied to load_req, defaults -> sel_out 1000,0100,0010,0001 each high 3 cycles in a 5-cycle period; frame_done once per 20 cycles.
- REQ-037 The bench SHALL cover: grp_en=4'b0101 -> only groups 0 and 2 shown (sel_out 1000, 0010); frame_done every 10 cycles.
- REQ-038 The bench SHALL cover: load_ack held low -> load_req high 4 cycles, then err_timeout=1 and sel_out driven 3 cycles; flag persists after ack resumes.
- REQ-039 The bench SHALL cover: hold_req=1, hold_sel=2 mid-scan -> current group completes, then sel_out=0010 repeats with frame_done each period; hold_sel=1 with grp_en[1]=0 -> normal scan.
- REQ-040 The bench SHALL cover: sl_rst_wire low mid-SHOW -> all outputs 0 immediately; after release, the scan restarts at group 0.
- REQ-041 The bench SHALL cover: build without DISP_BLANK_EN -> per-group period of 4 cycles and sel_out high on the cycle after ack.
